// File: rtl/can_pkg.sv
// can_pkg: shared frame record, register offsets and CAN ID width for the RX queue.
package can_pkg;
  localparam int ID_W = 29;
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic ext;
    logic rtr;
    logic [3:0] dlc;
    logic [63:0] data;
  } frame_t;
  localparam logic [2:0] RS_ID    = 3'd0;
  localparam logic [2:0] RS_STAT  = 3'd1;
  localparam logic [2:0] RS_DLO   = 3'd2;
  localparam logic [2:0] RS_DHI   = 3'd3;
  localparam logic [2:0] RS_CTRL  = 3'd4;
  localparam logic [2:0] RS_FSEL  = 3'd5;
  localparam logic [2:0] RS_FID   = 3'd6;
  localparam logic [2:0] RS_FMASK = 3'd7;
endpackage

// File: rtl/can_rx_queue_if.sv
// can_rx_queue_if: receiver frame strobe plus register bus of the CAN RX queue.
interface can_rx_queue_if;
  import can_pkg::*;
  logic in_valid;
  logic [ID_W-1:0] in_id;
  logic in_ext;
  logic in_rtr;
  logic [3:0] in_dlc;
  logic [63:0] in_data;
  logic cs;
  logic we;
  logic [2:0] rs;
  logic [31:0] d;
  logic [31:0] q;
  logic irq;
  modport master (output in_valid, in_id, in_ext, in_rtr, in_dlc, in_data, cs, we, rs, d,
                  input q, irq);
  modport slave (input in_valid, in_id, in_ext, in_rtr, in_dlc, in_data, cs, we, rs, d,
                 output q, irq);
endinterface

// File: rtl/can_acc_filter.sv
// can_acc_filter: one mask/ID acceptance comparator with optional ext-flag check.
module can_acc_filter
  import can_pkg::*;
(
  input  logic            en,
  input  logic [ID_W-1:0] id,
  input  logic [ID_W-1:0] mask,
  input  logic            ext,
  input  logic            extcmp,
  input  logic [ID_W-1:0] in_id,
  input  logic            in_ext,
  output logic            match
);
  always_comb match = en && (((in_id ^ id) & mask) == '0) && (!extcmp || (in_ext == ext));
endmodule

// File: rtl/can_rx_queue.sv
// can_rx_queue: filtered CAN frame FIFO with register access, overflow tracking and irq.
module can_rx_queue
  import can_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NFILT = 4
) (
  input logic clk,
  input logic reset,
  can_rx_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic [7:0] drop_q, drop_d;
  logic [1:0] ien_q, ien_d;
  logic [3:0] thresh_q, thresh_d;
  logic [2:0] fsel_q, fsel_d;
  logic [ID_W-1:0] fid_q [NFILT];
  logic [ID_W-1:0] fid_d [NFILT];
  logic [ID_W-1:0] fmask_q [NFILT];
  logic [ID_W-1:0] fmask_d [NFILT];
  logic [NFILT-1:0] fext_q, fext_d, fcmp_q, fcmp_d, fen_q, fen_d, hit;
  frame_t mem [DEPTH];
  frame_t head;
  logic wr, rd, ctrl, flush, clr, pop, empty, full, push, store, drop;
  for (genvar i = 0; i < NFILT; i++) begin : g_filt
    can_acc_filter u_filt (
      .en(fen_q[i]), .id(fid_q[i]), .mask(fmask_q[i]), .ext(fext_q[i]), .extcmp(fcmp_q[i]),
      .in_id(bus.in_id), .in_ext(bus.in_ext), .match(hit[i])
    );
  end
  always_comb begin
    wr = bus.cs && bus.we;
    rd = bus.cs && !bus.we;
    ctrl = wr && (bus.rs == RS_CTRL);
    flush = ctrl && bus.d[1];
    clr = ctrl && bus.d[2];
    empty = (cnt_q == '0);
    full = cnt_q[AW];
    pop = ctrl && bus.d[0] && !empty && !flush;
    push = bus.in_valid && ((|fen_q) ? (|hit) : 1'b1) && !flush;
    store = push && (!full || pop);
    drop = push && !store;
    head = empty ? '0 : mem[rp_q];
  end
  // flush resets both pointers so the queue restarts from slot 0
  always_comb begin
    wp_d = flush ? '0 : wp_q + AW'(store);
    rp_d = flush ? '0 : rp_q + AW'(pop);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(store) - (AW+1)'(pop);
    ovf_d = drop || (ovf_q && !clr);
    drop_d = clr ? '0 : drop_q;
    if (drop && drop_d != 8'hFF) drop_d = drop_d + 8'd1;
    ien_d = (ctrl && bus.d[31]) ? bus.d[9:8] : ien_q;
    thresh_d = (ctrl && bus.d[31]) ? bus.d[15:12] : thresh_q;
    fsel_d = (wr && bus.rs == RS_FSEL) ? bus.d[2:0] : fsel_q;
    fext_d = fext_q;
    fcmp_d = fcmp_q;
    fen_d = fen_q;
    for (int k = 0; k < NFILT; k++) begin
      fid_d[k] = fid_q[k];
      fmask_d[k] = fmask_q[k];
      if (wr && 3'(k) == fsel_q && bus.rs == RS_FID) begin
        fid_d[k] = bus.d[ID_W-1:0];
        fext_d[k] = bus.d[29];
      end
      if (wr && 3'(k) == fsel_q && bus.rs == RS_FMASK) begin
        fmask_d[k] = bus.d[ID_W-1:0];
        fcmp_d[k] = bus.d[29];
        fen_d[k] = bus.d[31];
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      drop_q <= '0;
      ien_q <= '0;
      thresh_q <= '0;
      fsel_q <= '0;
      fid_q <= '{default: '0};
      fmask_q <= '{default: '0};
      fext_q <= '0;
      fcmp_q <= '0;
      fen_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      drop_q <= drop_d;
      ien_q <= ien_d;
      thresh_q <= thresh_d;
      fsel_q <= fsel_d;
      fid_q <= fid_d;
      fmask_q <= fmask_d;
      fext_q <= fext_d;
      fcmp_q <= fcmp_d;
      fen_q <= fen_d;
    end
  end
  always_ff @(posedge clk) begin
    if (store) mem[wp_q] <= '{bus.in_id, bus.in_ext, bus.in_rtr, bus.in_dlc, bus.in_data};
  end
  always_comb begin
    bus.q = !rd ? '0 :
            (bus.rs == RS_ID)   ? {head.ext, head.rtr, 1'b0, head.id} :
            (bus.rs == RS_STAT) ? {8'd0, drop_q, 4'd0, 4'(cnt_q), 1'b0, ovf_q, full, empty, head.dlc} :
            (bus.rs == RS_DLO)  ? head.data[31:0] :
            (bus.rs == RS_DHI)  ? head.data[63:32] : '0;
    bus.irq = (ien_q[0] && (5'(cnt_q) >= 5'(thresh_q)) && (thresh_q != '0)) || (ien_q[1] && ovf_q);
  end
endmodule

// File: tb/tb_can_rx_queue.sv
// tb_can_rx_queue: directed stimulus with a read scoreboard checked by an independent monitor.
module tb_can_rx_queue;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  typedef struct {
    string name;
    logic [31:0] val;
    bit ci;
    bit irq;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  can_rx_queue_if bus ();
  can_rx_queue #(.DEPTH(4), .NFILT(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.cs && !bus.we) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_read: q=%h with no expectation queued", bus.q);
      end else begin
        e = sb.pop_front();
        if (bus.q !== e.val) begin
          n_err++;
          $display("FAIL %s: q got %h expected %h", e.name, bus.q, e.val);
        end
        if (e.ci) begin
          n_cmp++;
          if (bus.irq !== e.irq) begin
            n_err++;
            $display("FAIL %s_irq: irq got %b expected %b", e.name, bus.irq, e.irq);
          end
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [28:0] id, input logic ext, input logic rtr,
                      input logic [3:0] dlc, input logic [63:0] data);
    bus.in_valid = 1'b1;
    bus.in_id = id;
    bus.in_ext = ext;
    bus.in_rtr = rtr;
    bus.in_dlc = dlc;
    bus.in_data = data;
    tick();
    bus.in_valid = 1'b0;
  endtask
  task automatic wr(input logic [2:0] rs, input logic [31:0] d);
    bus.cs = 1'b1;
    bus.we = 1'b1;
    bus.rs = rs;
    bus.d = d;
    tick();
    bus.cs = 1'b0;
    bus.we = 1'b0;
  endtask
  task automatic rd(input string n, input logic [2:0] rs, input logic [31:0] v,
                    input bit ci = 1'b0, input bit ir = 1'b0);
    sb.push_back('{name: n, val: v, ci: ci, irq: ir});
    bus.cs = 1'b1;
    bus.we = 1'b0;
    bus.rs = rs;
    tick();
    bus.cs = 1'b0;
  endtask
  task automatic push_ctrl(input logic [28:0] id, input logic [3:0] dlc, input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_id = id;
    bus.in_ext = 1'b0;
    bus.in_rtr = 1'b0;
    bus.in_dlc = dlc;
    bus.in_data = 64'(id);
    bus.cs = 1'b1;
    bus.we = 1'b1;
    bus.rs = 3'd4;
    bus.d = d;
    tick();
    bus.in_valid = 1'b0;
    bus.cs = 1'b0;
    bus.we = 1'b0;
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_id = '0;
    bus.in_ext = 1'b0;
    bus.in_rtr = 1'b0;
    bus.in_dlc = '0;
    bus.in_data = '0;
    bus.cs = 1'b0;
    bus.we = 1'b0;
    bus.rs = '0;
    bus.d = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    rd("rst_stat", 3'd1, 32'h0000_0010, 1'b1, 1'b0);
    rd("rst_head", 3'd0, 32'h0);
    push(29'h123, 1'b0, 1'b0, 4'd2, 64'hBEEF);
    rd("basic_id", 3'd0, 32'h0000_0123);
    rd("basic_stat", 3'd1, 32'h0000_0102);
    rd("basic_dlo", 3'd2, 32'h0000_BEEF);
    rd("basic_dhi", 3'd3, 32'h0);
    wr(3'd4, 32'h1);
    rd("basic_pop", 3'd1, 32'h0000_0010);
    wr(3'd5, 32'h0);
    wr(3'd6, 32'h0000_0100);
    wr(3'd7, 32'h8000_0700);
    push(29'h1AB, 1'b0, 1'b0, 4'd1, 64'h0);
    push(29'h2AB, 1'b0, 1'b0, 4'd1, 64'h0);
    rd("filt_stat", 3'd1, 32'h0000_0101);
    rd("filt_id", 3'd0, 32'h0000_01AB);
    wr(3'd4, 32'h2);
    rd("filt_flush", 3'd1, 32'h0000_0010);
    wr(3'd6, 32'h2000_0100);
    wr(3'd7, 32'hA000_0700);
    push(29'h1AB, 1'b0, 1'b0, 4'd1, 64'h0);
    push(29'h1AB, 1'b1, 1'b1, 4'd0, 64'h0);
    wr(3'd5, 32'h5);
    wr(3'd7, 32'h8000_0000);
    push(29'h2AB, 1'b1, 1'b0, 4'd1, 64'h0);
    rd("extf_stat", 3'd1, 32'h0000_0100);
    rd("extf_id", 3'd0, 32'hC000_01AB);
    wr(3'd5, 32'h0);
    wr(3'd7, 32'h0);
    wr(3'd4, 32'h2);
    for (int i = 1; i <= 5; i++) push(29'(i), 1'b0, 1'b0, 4'd8, {32'(i) + 32'h100, 32'(i)});
    rd("ovf_stat", 3'd1, 32'h0001_0468);
    for (int i = 1; i <= 4; i++) begin
      rd($sformatf("order_id%0d", i), 3'd0, 32'(i));
      rd($sformatf("order_dhi%0d", i), 3'd3, 32'h100 + 32'(i));
      wr(3'd4, 32'h1);
    end
    rd("drain_stat", 3'd1, 32'h0001_0050);
    wr(3'd4, 32'h1);
    rd("empty_pop", 3'd1, 32'h0001_0050);
    wr(3'd4, 32'h4);
    rd("clr_ovf", 3'd1, 32'h0000_0010);
    for (int i = 0; i < 4; i++) push(29'h11 + 29'(i), 1'b0, 1'b0, 4'd3, 64'h0);
    push_ctrl(29'h15, 4'hF, 32'h1);
    rd("pp_stat", 3'd1, 32'h0000_0423);
    rd("pp_head", 3'd0, 32'h0000_0012);
    repeat (3) wr(3'd4, 32'h1);
    rd("pp_last", 3'd0, 32'h0000_0015);
    rd("pp_dlc15", 3'd1, 32'h0000_010F);
    rd("pp_data", 3'd2, 32'h0000_0015);
    wr(3'd4, 32'h2);
    wr(3'd4, 32'h8000_2100);
    push(29'h21, 1'b0, 1'b0, 4'd1, 64'h0);
    rd("thr_1", 3'd1, 32'h0000_0101, 1'b1, 1'b0);
    push(29'h22, 1'b0, 1'b0, 4'd1, 64'h0);
    rd("thr_2", 3'd1, 32'h0000_0201, 1'b1, 1'b1);
    wr(3'd4, 32'h1);
    rd("thr_pop", 3'd1, 32'h0000_0101, 1'b1, 1'b0);
    push_ctrl(29'h23, 4'd1, 32'h2);
    rd("flush_push", 3'd1, 32'h0000_0010, 1'b1, 1'b0);
    wr(3'd4, 32'h8000_0200);
    repeat (5) push(29'h30, 1'b0, 1'b0, 4'd1, 64'h0);
    rd("ovf_irq", 3'd1, 32'h0001_0461, 1'b1, 1'b1);
    repeat (258) push(29'h31, 1'b0, 1'b0, 4'd1, 64'h0);
    rd("drop_sat", 3'd1, 32'h00FF_0461, 1'b1, 1'b1);
    wr(3'd4, 32'h6);
    rd("clr_flush", 3'd1, 32'h0000_0010, 1'b1, 1'b0);
    wr(3'd4, 32'h8000_1100);
    wr(3'd6, 32'h0000_0100);
    wr(3'd7, 32'h8000_0700);
    push(29'h1AB, 1'b0, 1'b0, 4'd1, 64'h0);
    rd("pre_rst", 3'd1, 32'h0000_0101, 1'b1, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd("mid_rst_stat", 3'd1, 32'h0000_0010, 1'b1, 1'b0);
    rd("mid_rst_head", 3'd0, 32'h0);
    push(29'h2AB, 1'b0, 1'b0, 4'd2, 64'h0);
    rd("rst_filt_clr", 3'd0, 32'h0000_02AB);
    repeat (3) tick();
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_drain: %0d expectations left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
